prbs_checker: RTL and testbench

Receive-side PRBS bit-error-rate checker, the counterpart of the PRBS generator. It takes a recovered bit stream and self-synchronises to the selected PN polynomial. Once locked it compares every bit against a free-running local LFSR and counts bit errors, lock losses and checked bits. It sits in the dac_clk domain at the loopback/capture end of a PRBS link and is configured from the same pn_select register field as the generator.

---
 rtl/prbs_checker.sv | 217 +++++++++++++++++++++
 tb/tb_prbs_checker.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_checker.sv
// Receive-side PRBS bit-error-rate checker: self-synchronises to the selected PN polynomial,
// then checks each valid bit against a free-running local LFSR and tracks errors and lock.
module prbs_checker #(
  parameter int unsigned LOCK_COUNT  = 64,
  parameter int unsigned WINDOW      = 64,
  parameter int unsigned LOSS_THRESH = 8
) (
  input  logic        dac_clk,
  input  logic        reset_n,
  input  logic [3:0]  prbs_pn_select_in,
  input  logic        rx_bit_valid,
  input  logic        rx_bit,
  input  logic        clear_counters,
  output logic        locked,
  output logic        bit_err,
  output logic [31:0] err_count,
  output logic [31:0] bit_count,
  output logic [15:0] sync_loss_count,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StSeed   = 2'b01,
    StSync   = 2'b10,
    StLocked = 2'b11
  } state_e;

  localparam logic [7:0] LockLast  = 8'(LOCK_COUNT - 1);
  localparam logic [7:0] WinLast   = 8'(WINDOW - 1);
  localparam logic [7:0] LossLimit = 8'(LOSS_THRESH);

  state_e      state_q, state_d;
  logic [3:0]  sel_q;
  logic [30:0] hist_q, hist_d;
  logic [30:0] lfsr_q, lfsr_d;
  logic [4:0]  seed_q, seed_d;
  logic [7:0]  run_q, run_d;
  logic [7:0]  win_cnt_q, win_cnt_d;
  logic [7:0]  win_err_q, win_err_d;
  logic [31:0] err_q, err_d;
  logic [31:0] bits_q, bits_d;
  logic [15:0] loss_q, loss_d;
  logic        locked_q, locked_d;
  logic        bit_err_q, bit_err_d;

  logic        legal_sel, sel_change;
  logic [30:0] tap_mask, order_mask, hist_shift;
  logic [4:0]  seed_last;
  logic        hist_pred, hist_zero, lfsr_bit, mismatch, check_bit;
  logic        err_inc, bit_inc, loss_inc;

  assign legal_sel  = (prbs_pn_select_in <= 4'd5);
  assign sel_change = (prbs_pn_select_in != sel_q);

  // Taps of x^N + x^T + 1 sit at bit N-1 and T-1, with bit 0 holding the newest bit.
  always_comb begin
    case (sel_q)
      4'd0:    begin tap_mask = 31'h0000_0006; order_mask = 31'h0000_0007; seed_last = 5'd2;  end
      4'd1:    begin tap_mask = 31'h0000_0060; order_mask = 31'h0000_007F; seed_last = 5'd6;  end
      4'd2:    begin tap_mask = 31'h0000_0110; order_mask = 31'h0000_01FF; seed_last = 5'd8;  end
      4'd3:    begin tap_mask = 31'h0000_6000; order_mask = 31'h0000_7FFF; seed_last = 5'd14; end
      4'd4:    begin tap_mask = 31'h0042_0000; order_mask = 31'h007F_FFFF; seed_last = 5'd22; end
      4'd5:    begin tap_mask = 31'h4800_0000; order_mask = 31'h7FFF_FFFF; seed_last = 5'd30; end
      default: begin tap_mask = 31'h0000_0006; order_mask = 31'h0000_0007; seed_last = 5'd2;  end
    endcase
  end

  assign hist_shift = {hist_q[29:0], rx_bit};
  assign hist_pred  = ^(hist_q & tap_mask);
  assign hist_zero  = ((hist_q & order_mask) == '0);
  assign lfsr_bit   = ^(lfsr_q & tap_mask);
  assign mismatch   = (rx_bit != lfsr_bit);
  assign check_bit  = rx_bit_valid && legal_sel && !sel_change && (state_q == StLocked);

  // Next-state and datapath.
  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    lfsr_d    = lfsr_q;
    seed_d    = seed_q;
    run_d     = run_q;
    win_cnt_d = win_cnt_q;
    win_err_d = win_err_q;
    err_inc   = 1'b0;
    bit_inc   = 1'b0;
    loss_inc  = 1'b0;

    if (!legal_sel) begin
      state_d = StIdle;
      seed_d  = '0;
      run_d   = '0;
    end else if (sel_change) begin
      // Reconfiguration restarts acquisition; it is not counted as a loss of lock.
      state_d = StSeed;
      seed_d  = '0;
      run_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: state_d = StSeed;
        StSeed: begin
          if (rx_bit_valid) begin
            hist_d = hist_shift;
            if (seed_q == seed_last) begin
              seed_d  = '0;
              run_d   = '0;
              state_d = StSync;
            end else begin
              seed_d = seed_q + 5'd1;
            end
          end
        end
        StSync: begin
          if (rx_bit_valid) begin
            hist_d = hist_shift;
            if (hist_zero || (rx_bit != hist_pred)) begin
              run_d = '0;
            end else if (run_q == LockLast) begin
              state_d   = StLocked;
              lfsr_d    = hist_shift;
              run_d     = '0;
              win_cnt_d = '0;
              win_err_d = '0;
            end else begin
              run_d = run_q + 8'd1;
            end
          end
        end
        StLocked: begin
          if (rx_bit_valid) begin
            hist_d  = hist_shift;
            lfsr_d  = {lfsr_q[29:0], lfsr_bit};
            bit_inc = 1'b1;
            err_inc = mismatch;
            if ((win_err_q + {7'd0, mismatch}) >= LossLimit) begin
              state_d   = StSeed;
              seed_d    = '0;
              run_d     = '0;
              win_cnt_d = '0;
              win_err_d = '0;
              loss_inc  = 1'b1;
            end else if (win_cnt_q == WinLast) begin
              win_cnt_d = '0;
              win_err_d = '0;
            end else begin
              win_cnt_d = win_cnt_q + 8'd1;
              win_err_d = win_err_q + {7'd0, mismatch};
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Saturating counters; a clear wins over a simultaneous increment.
  always_comb begin
    err_d  = err_q;
    bits_d = bits_q;
    loss_d = loss_q;
    if (clear_counters) begin
      err_d  = '0;
      bits_d = '0;
      loss_d = '0;
    end else begin
      if (err_inc && (err_q != '1))   err_d  = err_q + 32'd1;
      if (bit_inc && (bits_q != '1))  bits_d = bits_q + 32'd1;
      if (loss_inc && (loss_q != '1)) loss_d = loss_q + 16'd1;
    end
  end

  // Output next-state.
  always_comb begin
    locked_d  = (state_d == StLocked);
    bit_err_d = check_bit && mismatch;
  end

  always_ff @(posedge dac_clk) begin
    if (!reset_n) begin
      sel_q     <= 4'd0;
      state_q   <= StIdle;
      hist_q    <= '0;
      lfsr_q    <= '0;
      seed_q    <= '0;
      run_q     <= '0;
      win_cnt_q <= '0;
      win_err_q <= '0;
      err_q     <= '0;
      bits_q    <= '0;
      loss_q    <= '0;
      locked_q  <= 1'b0;
      bit_err_q <= 1'b0;
    end else begin
      sel_q     <= prbs_pn_select_in;
      state_q   <= state_d;
      hist_q    <= hist_d;
      lfsr_q    <= lfsr_d;
      seed_q    <= seed_d;
      run_q     <= run_d;
      win_cnt_q <= win_cnt_d;
      win_err_q <= win_err_d;
      err_q     <= err_d;
      bits_q    <= bits_d;
      loss_q    <= loss_d;
      locked_q  <= locked_d;
      bit_err_q <= bit_err_d;
    end
  end

  assign locked          = locked_q;
  assign bit_err         = bit_err_q;
  assign err_count       = err_q;
  assign bit_count       = bits_q;
  assign sync_loss_count = loss_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: directed PRBS streams checked every cycle against a queue-based model,
// plus literal lock/loss latencies.
module tb_prbs_checker;

  localparam int unsigned LockCount  = 64;
  localparam int unsigned Window     = 64;
  localparam int unsigned LossThresh = 8;

  logic        dac_clk = 1'b0;
  logic        reset_n;
  logic [3:0]  prbs_pn_select_in;
  logic        rx_bit_valid;
  logic        rx_bit;
  logic        clear_counters;
  logic        locked;
  logic        bit_err;
  logic [31:0] err_count;
  logic [31:0] bit_count;
  logic [15:0] sync_loss_count;
  logic [1:0]  state_dbg;

  always #5 dac_clk = ~dac_clk;

  prbs_checker #(
    .LOCK_COUNT (LockCount),
    .WINDOW     (Window),
    .LOSS_THRESH(LossThresh)
  ) dut (
    .dac_clk          (dac_clk),
    .reset_n          (reset_n),
    .prbs_pn_select_in(prbs_pn_select_in),
    .rx_bit_valid     (rx_bit_valid),
    .rx_bit           (rx_bit),
    .clear_counters   (clear_counters),
    .locked           (locked),
    .bit_err          (bit_err),
    .err_count        (err_count),
    .bit_count        (bit_count),
    .sync_loss_count  (sync_loss_count),
    .state_dbg        (state_dbg)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int order_of(input logic [3:0] s);
    case (s)
      4'd0: return 3;
      4'd1: return 7;
      4'd2: return 9;
      4'd3: return 15;
      4'd4: return 23;
      4'd5: return 31;
      default: return 3;
    endcase
  endfunction

  function automatic int tap_of(input logic [3:0] s);
    case (s)
      4'd0: return 2;
      4'd1: return 6;
      4'd2: return 5;
      4'd3: return 14;
      4'd4: return 18;
      4'd5: return 28;
      default: return 2;
    endcase
  endfunction

  // Model: hb holds received bits (newest last), lq the locally predicted sequence.
  int          m_state;
  logic [3:0]  m_sel;
  bit          hb[$];
  bit          lq[$];
  int          m_seed, m_run, m_wn, m_we;
  logic [31:0] m_err, m_bits;
  logic [15:0] m_loss;
  bit          e_bit_err;

  task automatic push_hist(input bit b);
    hb.push_back(b);
    if (hb.size() > 31) void'(hb.pop_front());
  endtask

  task automatic model_step(input bit rst, input bit v, input bit b, input logic [3:0] sel,
                            input bit clr);
    int n;
    int t;
    bit pred;
    bit zero;
    bit exp_b;
    e_bit_err = 1'b0;
    if (rst) begin
      m_state = 0;
      m_sel   = 4'd0;
      hb.delete();
      repeat (31) hb.push_back(1'b0);
      lq.delete();
      m_seed = 0; m_run = 0; m_wn = 0; m_we = 0;
      m_err = 0; m_bits = 0; m_loss = 0;
      return;
    end
    n = order_of(sel);
    t = tap_of(sel);
    if (sel > 4'd5) begin
      m_state = 0; m_seed = 0; m_run = 0;
    end else if (sel != m_sel) begin
      m_state = 1; m_seed = 0; m_run = 0;
    end else begin
      case (m_state)
        0: m_state = 1;
        1: if (v) begin
          push_hist(b);
          m_seed++;
          if (m_seed == n) begin
            m_seed = 0; m_run = 0; m_state = 2;
          end
        end
        2: if (v) begin
          pred = hb[hb.size() - n] ^ hb[hb.size() - t];
          zero = 1'b1;
          for (int i = 1; i <= n; i++) if (hb[hb.size() - i]) zero = 1'b0;
          push_hist(b);
          if (zero || b != pred) m_run = 0;
          else m_run++;
          if (m_run == LockCount) begin
            m_state = 3; m_run = 0; m_wn = 0; m_we = 0;
            lq.delete();
            for (int i = hb.size() - n; i < hb.size(); i++) lq.push_back(hb[i]);
          end
        end
        default: if (v) begin
          exp_b = lq[lq.size() - n] ^ lq[lq.size() - t];
          lq.push_back(exp_b);
          if (lq.size() > 64) void'(lq.pop_front());
          push_hist(b);
          if (m_bits != 32'hFFFF_FFFF) m_bits = m_bits + 1;
          m_wn++;
          if (b != exp_b) begin
            e_bit_err = 1'b1;
            if (m_err != 32'hFFFF_FFFF) m_err = m_err + 1;
            m_we++;
          end
          if (m_we >= LossThresh) begin
            m_state = 1; m_seed = 0; m_run = 0;
            if (m_loss != 16'hFFFF) m_loss = m_loss + 1;
          end else if (m_wn == Window) begin
            m_wn = 0; m_we = 0;
          end
        end
      endcase
    end
    if (clr) begin
      m_err = 0; m_bits = 0; m_loss = 0;
    end
    m_sel = sel;
  endtask

  always @(negedge dac_clk) begin
    if (chk_en) begin
      chk("state_dbg", 64'(state_dbg), 64'(m_state));
      chk("locked", 64'(locked), 64'(m_state == 3));
      chk("bit_err", 64'(bit_err), 64'(e_bit_err));
      chk("err_count", 64'(err_count), 64'(m_err));
      chk("bit_count", 64'(bit_count), 64'(m_bits));
      chk("sync_loss_count", 64'(sync_loss_count), 64'(m_loss));
    end
  end

  // Reference PRBS generator: seeds N ones, then s[n] = s[n-N] ^ s[n-T].
  bit gs[$];
  int g_n, g_t;

  task automatic gen_start(input logic [3:0] s);
    gs.delete();
    g_n = order_of(s);
    g_t = tap_of(s);
  endtask

  task automatic gen_bit(output bit o);
    bit nb;
    if (gs.size() < g_n) nb = 1'b1;
    else nb = gs[gs.size() - g_n] ^ gs[gs.size() - g_t];
    gs.push_back(nb);
    if (gs.size() > 40) void'(gs.pop_front());
    o = nb;
  endtask

  int pulses = 0;

  task automatic drive(input bit v, input bit b, input bit clr = 1'b0);
    rx_bit_valid   = v;
    rx_bit         = b;
    clear_counters = clr;
    model_step(!reset_n, v, b, prbs_pn_select_in, clr);
    chk_en = 1'b1;
    @(posedge dac_clk);
    @(negedge dac_clk);
    #1;
    if (bit_err) pulses++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  bit         b;
  logic [6:0] pat;
  int         lock_at, lost_at, relock_at, lock_cyc, lock_v, vb;
  bit         ever_locked;

  initial begin
    reset_n           = 1'b0;
    prbs_pn_select_in = 4'd1;
    rx_bit_valid      = 1'b0;
    rx_bit            = 1'b0;
    clear_counters    = 1'b0;
    @(negedge dac_clk);
    #1;
    drive(0, 0);
    drive(0, 0);
    chk("reset_state", 64'(state_dbg), 64'(0));
    chk("reset_locked", 64'(locked), 64'(0));
    chk("reset_err", 64'(err_count), 64'(0));

    gen_start(4'd0);
    pat = '0;
    for (int i = 0; i < 7; i++) begin
      gen_bit(b);
      pat = {pat[5:0], b};
    end
    chk("pn3_sequence", 64'(pat), 64'(7'b1110010));

    // PN7 clean, valid every cycle.
    reset_n = 1'b1;
    drive(0, 0);
    chk("idle_to_seed", 64'(state_dbg), 64'(1));
    gen_start(4'd1);
    lock_at = 0;
    for (int i = 1; i <= 90; i++) begin
      gen_bit(b);
      drive(1, b);
      if (locked && lock_at == 0) lock_at = i;
      if (i == 81) chk("pn7_bit_count", 64'(bit_count), 64'(10));
    end
    chk("pn7_lock_bit", 64'(lock_at), 64'(71));
    chk("pn7_state", 64'(state_dbg), 64'(3));
    chk("pn7_err", 64'(err_count), 64'(0));

    // PN9, one flipped bit.
    prbs_pn_select_in = 4'd2;
    drive(0, 0, 1);
    chk("pn9_seed", 64'(state_dbg), 64'(1));
    gen_start(4'd2);
    lock_at = 0;
    pulses  = 0;
    for (int i = 1; i <= 260; i++) begin
      gen_bit(b);
      if (i == 200) b = ~b;
      drive(1, b);
      if (locked && lock_at == 0) lock_at = i;
    end
    chk("pn9_lock_bit", 64'(lock_at), 64'(73));
    chk("pn9_pulses", 64'(pulses), 64'(1));
    chk("pn9_err", 64'(err_count), 64'(1));
    chk("pn9_locked", 64'(locked), 64'(1));

    // PN7, eight flips inside one window.
    prbs_pn_select_in = 4'd1;
    drive(0, 0, 1);
    gen_start(4'd1);
    lock_at = 0; lost_at = 0; relock_at = 0;
    for (int i = 1; i <= 180; i++) begin
      gen_bit(b);
      if (i >= 80 && i <= 94 && (i % 2) == 0) b = ~b;
      drive(1, b);
      if (locked && lock_at == 0) lock_at = i;
      else if (!locked && lock_at != 0 && lost_at == 0) begin
        lost_at = i;
        chk("burst_loss_count", 64'(sync_loss_count), 64'(1));
      end else if (locked && lost_at != 0 && relock_at == 0) relock_at = i;
    end
    chk("burst_lock_bit", 64'(lock_at), 64'(71));
    chk("burst_lost_bit", 64'(lost_at), 64'(94));
    chk("burst_relock_bit", 64'(relock_at), 64'(165));
    chk("burst_err", 64'(err_count), 64'(8));

    // Constant zero stream on PN15.
    prbs_pn_select_in = 4'd3;
    drive(0, 0, 1);
    ever_locked = 1'b0;
    for (int i = 1; i <= 150; i++) begin
      drive(1, 0);
      if (locked) ever_locked = 1'b1;
    end
    chk("zero_state", 64'(state_dbg), 64'(2));
    chk("zero_never_locked", 64'(ever_locked), 64'(0));
    chk("zero_err", 64'(err_count), 64'(0));

    // Select change while locked.
    prbs_pn_select_in = 4'd1;
    drive(0, 0, 1);
    gen_start(4'd1);
    for (int i = 1; i <= 80; i++) begin
      gen_bit(b);
      drive(1, b);
    end
    chk("switch_pre_locked", 64'(locked), 64'(1));
    prbs_pn_select_in = 4'd3;
    drive(0, 0);
    chk("switch_seed", 64'(state_dbg), 64'(1));
    gen_start(4'd3);
    lock_at = 0;
    for (int i = 1; i <= 100; i++) begin
      gen_bit(b);
      drive(1, b);
      if (locked && lock_at == 0) lock_at = i;
    end
    chk("switch_lock_bit", 64'(lock_at), 64'(79));
    chk("switch_err", 64'(err_count), 64'(0));
    prbs_pn_select_in = 4'd9;
    drive(0, 0);
    chk("reserved_idle", 64'(state_dbg), 64'(0));
    drive(1, 1);
    chk("reserved_stays_idle", 64'(state_dbg), 64'(0));

    // PN3 with valid toggling every cycle.
    prbs_pn_select_in = 4'd0;
    drive(0, 0, 1);
    gen_start(4'd0);
    vb = 0; lock_cyc = 0; lock_v = 0;
    for (int c = 1; c <= 160; c++) begin
      if ((c % 2) == 1) begin
        gen_bit(b);
        vb++;
        drive(1, b);
      end else begin
        drive(0, 0);
      end
      if (locked && lock_cyc == 0) begin
        lock_cyc = c;
        lock_v   = vb;
      end
    end
    chk("gap_lock_valid_bits", 64'(lock_v), 64'(67));
    chk("gap_lock_cycle", 64'(lock_cyc), 64'(133));
    gen_bit(b);
    pulses = 0;
    drive(1, ~b, 1);
    chk("clear_flip_pulse", 64'(pulses), 64'(1));
    chk("clear_flip_err", 64'(err_count), 64'(0));
    for (int i = 0; i < 10; i++) begin
      gen_bit(b);
      drive(1, b);
    end
    chk("clear_after_err", 64'(err_count), 64'(0));
    chk("clear_after_bits", 64'(bit_count), 64'(10));
    chk("clear_locked", 64'(locked), 64'(1));

    // Reset mid-operation.
    reset_n = 1'b0;
    drive(1, 0);
    chk("midreset_state", 64'(state_dbg), 64'(0));
    chk("midreset_bits", 64'(bit_count), 64'(0));
    reset_n = 1'b1;
    drive(0, 0);
    chk("midreset_seed", 64'(state_dbg), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
